// File: rtl/stack_pkg.sv
// Shared encodings for the Forth data stack and its command sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package stack_pkg;

    // Command opcodes carried on CmdOp
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_DROP = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;
    localparam logic [2:0] OP_NIP  = 3'd7;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;

    // Signed stack-pointer offset; 2'b10 is never used
    localparam logic [1:0] OFS_HOLD = 2'b00;
    localparam logic [1:0] OFS_PUSH = 2'b01;
    localparam logic [1:0] OFS_POP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_SWAP_B = 2'd2,
        ST_RSP    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/stack.sv
// Forth data stack: word array with a pointer moved by a signed offset; T/N read combinationally.
// Latency: offset and slot writes take effect at the edge they are presented; T/N follow immediately.
// Backpressure: none; the driver must not over/underflow it (pointer saturates as a safety net).
//
// Ports: Clk/Rst (async active-low), TWrite/NWrite write the T/N slot as seen after
// the offset is applied, WData write data, Offset 00 hold/01 push/11 pop, T/N top words
// (zero when the slot is empty).
module stack
    import stack_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    localparam int DW   = $clog2(DEPTH) + 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         TWrite,
    input  logic         NWrite,
    input  logic [W-1:0] WData,
    input  logic [1:0]   Offset,
    output logic [W-1:0] T,
    output logic [W-1:0] N
);

    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] t_idx, n_idx;
    logic          t_we, n_we;

    always_comb begin
        cnt_d = cnt_q;
        unique case (Offset)
            OFS_PUSH: if (cnt_q != FULL)   cnt_d = cnt_q + DW'(1);
            OFS_POP:  if (cnt_q != '0)     cnt_d = cnt_q - DW'(1);
            default:  cnt_d = cnt_q;
        endcase
        // Slot addresses are relative to the post-offset pointer
        t_idx = AW'(cnt_d - DW'(1));
        n_idx = AW'(cnt_d - DW'(2));
        t_we  = TWrite && (cnt_d != '0);
        n_we  = NWrite && (cnt_d >= DW'(2));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    always_ff @(posedge Clk) begin
        if (t_we) mem_q[t_idx] <= WData;
        if (n_we) mem_q[n_idx] <= WData;
    end

    assign T = (cnt_q != '0)       ? mem_q[AW'(cnt_q - DW'(1))] : '0;
    assign N = (cnt_q >= DW'(2))   ? mem_q[AW'(cnt_q - DW'(2))] : '0;

endmodule

// File: rtl/stack_sequencer.sv
// Forth stack command front end: one primitive per CmdValid/CmdReady handshake, drives stack writes.
// Latency: stack controls in cycle k+1 after acceptance edge k; ready again k+2 (SWAP k+3, POP after RspReady).
// Backpressure: CmdReady low while a command executes; POP holds RspValid until RspReady.
//
// Ports: Cmd* command handshake (op, PUSH literal), Rsp* POP result handshake,
// Err one-cycle error pulse, ErrCode sticky last error, Depth mirrored stack depth,
// TWrite/NWrite/WData/Offset stack write interface, T/N stack top words read back.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    localparam int DW   = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          CmdValid,
    output logic          CmdReady,
    input  logic [2:0]    CmdOp,
    input  logic [W-1:0]  CmdData,
    output logic          RspValid,
    input  logic          RspReady,
    output logic [W-1:0]  RspData,
    output logic          Err,
    output logic [1:0]    ErrCode,
    output logic [DW-1:0] Depth,
    output logic          TWrite,
    output logic          NWrite,
    output logic [W-1:0]  WData,
    output logic [1:0]    Offset,
    input  logic [W-1:0]  T,
    input  logic [W-1:0]  N
);

    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    seq_state_t    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  swap_q, swap_d;
    logic [W-1:0]  rsp_q, rsp_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;

    // Stack controls depend on T/N in the same cycle, so they are combinational
    logic          t_write, n_write;
    logic [W-1:0]  w_data;
    logic [1:0]    offset;
    logic          under, over;

    always_comb begin
        // Bounds check for the latched op against the mirrored depth
        under = 1'b0;
        over  = 1'b0;
        unique case (op_q)
            OP_PUSH:          over  = (depth_q == FULL);
            OP_DUP: begin
                under = (depth_q == '0);
                over  = (depth_q == FULL);
            end
            OP_OVER: begin
                under = (depth_q < DW'(2));
                over  = (depth_q == FULL);
            end
            OP_POP, OP_DROP:  under = (depth_q == '0);
            OP_SWAP, OP_NIP:  under = (depth_q < DW'(2));
            default:          ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        swap_d     = swap_q;
        rsp_d      = rsp_q;
        depth_d    = depth_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        t_write    = 1'b0;
        n_write    = 1'b0;
        w_data     = '0;
        offset     = OFS_HOLD;

        unique case (state_q)
            ST_IDLE: begin
                // NOP is consumed here without an execute cycle
                if (CmdValid && (CmdOp != OP_NOP)) begin
                    op_d    = CmdOp;
                    data_d  = CmdData;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_IDLE;
                if (under) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_UNDER;
                end else if (over) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVER;
                end else begin
                    unique case (op_q)
                        OP_PUSH: begin
                            offset  = OFS_PUSH;
                            t_write = 1'b1;
                            w_data  = data_q;
                            depth_d = depth_q + DW'(1);
                        end
                        OP_DUP: begin
                            offset  = OFS_PUSH;
                            t_write = 1'b1;
                            w_data  = T;
                            depth_d = depth_q + DW'(1);
                        end
                        OP_OVER: begin
                            offset  = OFS_PUSH;
                            t_write = 1'b1;
                            w_data  = N;
                            depth_d = depth_q + DW'(1);
                        end
                        OP_POP: begin
                            offset  = OFS_POP;
                            rsp_d   = T;
                            depth_d = depth_q - DW'(1);
                            state_d = ST_RSP;
                        end
                        OP_DROP: begin
                            offset  = OFS_POP;
                            depth_d = depth_q - DW'(1);
                        end
                        OP_NIP: begin
                            // After the pop, the T slot is the old N slot
                            offset  = OFS_POP;
                            t_write = 1'b1;
                            w_data  = T;
                            depth_d = depth_q - DW'(1);
                        end
                        OP_SWAP: begin
                            // First half: old T into N; old N parked for SWAP_B
                            n_write = 1'b1;
                            w_data  = T;
                            swap_d  = N;
                            state_d = ST_SWAP_B;
                        end
                        default: ;
                    endcase
                end
            end

            ST_SWAP_B: begin
                t_write = 1'b1;
                w_data  = swap_q;
                state_d = ST_IDLE;
            end

            ST_RSP: begin
                if (RspReady) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            data_q     <= '0;
            swap_q     <= '0;
            rsp_q      <= '0;
            depth_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            swap_q     <= swap_d;
            rsp_q      <= rsp_d;
            depth_q    <= depth_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Gated by Rst so ready is low during reset yet high in the first cycle after release
    assign CmdReady = (state_q == ST_IDLE) && Rst;
    assign RspValid = (state_q == ST_RSP);
    assign RspData  = rsp_q;
    assign Err      = err_q;
    assign ErrCode  = err_code_q;
    assign Depth    = depth_q;
    assign TWrite   = t_write;
    assign NWrite   = n_write;
    assign WData    = w_data;
    assign Offset   = offset;

endmodule
